// File: rtl/tea_pkg.sv
// tea_pkg: shared constants, state encoding and round mixing function for tea_core
package tea_pkg;
  localparam logic [15:0] DELTA = 16'h9E37;
  localparam logic [9:0] ENTRY_ENC = 10'h080;
  localparam logic [9:0] ENTRY_DEC = 10'h164;
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;
  typedef enum logic [2:0] {HOLD, LD_PARAM, LD_DATA, LD_KEY, ROUND, ST_DATA, DONE} state_t;
  function automatic logic [15:0] mix(input logic [15:0] v, input logic [15:0] ka, input logic [15:0] kb, input logic [15:0] s);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction
endpackage

// File: rtl/tea_round.sv
// tea_round: one combinational TEA round, encrypt or decrypt
module tea_round (
  input  logic        enc,
  input  logic [15:0] v0,
  input  logic [15:0] v1,
  input  logic [15:0] k0,
  input  logic [15:0] k1,
  input  logic [15:0] k2,
  input  logic [15:0] k3,
  input  logic [15:0] sum,
  output logic [15:0] v0_n,
  output logic [15:0] v1_n,
  output logic [15:0] sum_n
);
  import tea_pkg::*;
  logic [15:0] s_enc, v0_e, v1_e, v0_d, v1_d;
  assign s_enc = sum + DELTA;
  assign v0_e  = v0 + mix(v1, k0, k1, s_enc);
  assign v1_e  = v1 + mix(v0_e, k2, k3, s_enc);
  assign v1_d  = v1 - mix(v0, k2, k3, sum);
  assign v0_d  = v0 - mix(v1_d, k0, k1, sum);
  assign v0_n  = enc ? v0_e : v0_d;
  assign v1_n  = enc ? v1_e : v1_d;
  assign sum_n = enc ? s_enc : sum - DELTA;
endmodule

// File: rtl/tea_core.sv
// tea_core: bus-mastering TEA engine that encrypts/decrypts a 32-bit block in place
module tea_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        setb,
  output logic        idle,
  input  logic [9:0]  pc0,
  input  logic [31:0] a00,
  input  logic [31:0] ra0,
  input  logic [31:0] a40,
  input  logic [31:0] a50,
  input  logic [31:0] sp0,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        valid,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);
  import tea_pkg::*;
  state_t state, state_n;
  logic [9:0] pc_q;
  logic [31:0] a_q, dat_p, key_p, req_addr;
  logic [15:0] rounds, v0, v1, sum, half, v0_n, v1_n, sum_n;
  logic [15:0] k [4];
  logic [1:0] idx, last_idx;
  logic [2:0] req_size;
  logic enc, entry, xfer, last, bus_st;
  logic unused_ctx;
  assign unused_ctx = ^{ra0, a40, a50, sp0};
  assign enc   = pc_q == ENTRY_ENC;
  assign entry = enc | (pc_q == ENTRY_DEC);
  assign xfer  = valid & ready;
  assign last  = idx == last_idx;
  assign half  = rdata[{addr[1], 4'b0000} +: 16];
  assign idle  = (state == DONE) | ((state == HOLD) & ~setb);
  tea_round u_round (
    .enc(enc), .v0(v0), .v1(v1), .k0(k[0]), .k1(k[1]), .k2(k[2]), .k3(k[3]),
    .sum(sum), .v0_n(v0_n), .v1_n(v1_n), .sum_n(sum_n)
  );
  // Address, size and transfer count for the pending bus request of the current phase
  always_comb begin
    last_idx = state == LD_PARAM ? 2'd2 : state == LD_KEY ? 2'd3 : 2'd1;
    bus_st   = state inside {LD_PARAM, LD_DATA, LD_KEY, ST_DATA};
    req_addr = state == LD_PARAM ? a_q + {28'd0, idx, 2'b00}
             : (state == LD_KEY ? key_p : dat_p) + {29'd0, idx, 1'b0};
    req_size = state == LD_PARAM ? SIZE_WORD : SIZE_HALF;
  end
  // State register
  always_ff @(posedge clk)
    if (rst) state <= HOLD;
    else state <= state_n;
  // Next-state logic; DONE waits for setb to drop so a held setb cannot rerun
  always_comb begin
    state_n = state;
    case (state)
      HOLD:     if (setb) state_n = entry ? LD_PARAM : DONE;
      LD_PARAM: if (xfer && last) state_n = LD_DATA;
      LD_DATA:  if (xfer && last) state_n = LD_KEY;
      LD_KEY:   if (xfer && last) state_n = ROUND;
      ROUND:    if (rounds == '0) state_n = ST_DATA;
      ST_DATA:  if (xfer && last) state_n = DONE;
      DONE:     if (!setb) state_n = HOLD;
      default:  state_n = HOLD;
    endcase
  end
  // Bus master: request held until ready, then one idle cycle before the next request
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      write <= 1'b0;
      addr  <= '0;
      size  <= SIZE_BYTE;
      wdata <= '0;
      idx   <= '0;
      pc_q  <= '0;
      a_q   <= '0;
    end else begin
      if (state == HOLD && !setb) begin
        pc_q <= pc0;
        a_q  <= a00;
      end
      if (xfer) begin
        valid <= 1'b0;
        idx   <= last ? 2'd0 : idx + 2'd1;
      end else if (bus_st && !valid) begin
        valid <= 1'b1;
        addr  <= req_addr;
        size  <= req_size;
        write <= state == ST_DATA;
        wdata <= {16'h0000, idx[0] ? v1 : v0};
      end
    end
  // Datapath: capture read data per phase and advance one round per cycle
  always_ff @(posedge clk) begin
    if (xfer && state == LD_PARAM)
      case (idx)
        2'd0: begin
          rounds <= rdata[15:0];
          sum    <= enc ? 16'h0000 : 16'(DELTA * rdata[15:0]);
        end
        2'd1:    dat_p <= rdata;
        default: key_p <= rdata;
      endcase
    if (xfer && state == LD_DATA) begin
      if (idx[0]) v1 <= half;
      else v0 <= half;
    end
    if (xfer && state == LD_KEY) k[idx] <= half;
    if (state == ROUND && rounds != '0) begin
      v0     <= v0_n;
      v1     <= v1_n;
      sum    <= sum_n;
      rounds <= rounds - 16'd1;
    end
  end
endmodule

// File: tb/tb_tea_core.sv
// tb_tea_core: directed self-checking bench for tea_core with a byte-array memory slave
module tb_tea_core;
  logic clk = 1'b0;
  logic rst, setb, idle, valid, write, ready;
  logic [9:0] pc0;
  logic [31:0] a00, addr, wdata, rdata;
  logic [31:0] ra0 = '0, a40 = '0, a50 = '0, sp0 = '0;
  logic [2:0] size;
  logic [7:0] mem [0:8191];
  int n_assert = 0, n_fail = 0;
  int delay_max = 0, cnt = 0;
  int xfers = 0, wr_cnt = 0, vld_cyc = 0;
  logic unstable = 1'b0, pv = 1'b0;
  logic [31:0] pa = '0;
  localparam logic [31:0] PLAIN = 32'h74696873;
  localparam logic [31:0] CIPH1 = 32'h50B678F2;
  tea_core dut (
    .clk(clk), .rst(rst), .setb(setb), .idle(idle), .pc0(pc0), .a00(a00),
    .ra0(ra0), .a40(a40), .a50(a50), .sp0(sp0), .addr(addr), .size(size),
    .valid(valid), .write(write), .wdata(wdata), .rdata(rdata), .ready(ready)
  );
  always #5 clk = ~clk;
  assign rdata = {mem[{addr[12:2], 2'd3}], mem[{addr[12:2], 2'd2}], mem[{addr[12:2], 2'd1}], mem[{addr[12:2], 2'd0}]};
  // Slave: ready follows valid after a random wait, performs writes on the handshake
  always @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      cnt = 0;
    end else if (valid && !ready) begin
      if (cnt == 0) ready <= 1'b1;
      else cnt = cnt - 1;
    end else begin
      ready <= 1'b0;
      cnt = $urandom_range(0, delay_max);
    end
    if (valid) vld_cyc++;
    if (valid && ready) begin
      xfers++;
      if (write) begin
        wr_cnt++;
        mem[addr[12:0]] = wdata[7:0];
        if (size == 3'd1) mem[addr[12:0] + 13'd1] = wdata[15:8];
      end
    end
    if (pv && (!valid || addr !== pa)) unstable = 1'b1;
    pv = valid && !ready;
    pa = addr;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic put_word(input logic [12:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 13'(i)] = w[8*i +: 8];
  endtask
  function automatic logic [31:0] data_word();
    return {mem[13'h1103], mem[13'h1102], mem[13'h1101], mem[13'h1100]};
  endfunction
  task automatic setup(input logic [31:0] rounds, input logic [31:0] data);
    put_word(13'h1000, rounds);
    put_word(13'h1004, 32'h00001100);
    put_word(13'h1008, 32'h00001200);
    put_word(13'h1100, data);
    put_word(13'h1200, 32'h56781234);
    put_word(13'h1204, 32'hDEF19ABC);
  endtask
  task automatic run(input string tag, input logic [9:0] pc);
    @(negedge clk);
    pc0 = pc;
    a00 = 32'h00001000;
    xfers = 0;
    wr_cnt = 0;
    vld_cyc = 0;
    unstable = 1'b0;
    @(negedge clk);
    setb = 1'b1;
    #1 chk({tag, "_idle_fall"}, 32'(idle), 32'd0);
    for (int i = 0; i < 5000 && !idle; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(idle), 32'd1);
    @(negedge clk);
    setb = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    rst = 1'b1;
    setb = 1'b0;
    pc0 = 10'h000;
    a00 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_size", 32'(size), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    setup(32'd1, PLAIN);
    run("enc1", 10'h080);
    chk("enc1_data", data_word(), CIPH1);
    chk("enc1_xfers", 32'(xfers), 32'd11);
    chk("enc1_writes", 32'(wr_cnt), 32'd2);
    setup(32'd10, PLAIN);
    run("rt_enc", 10'h080);
    n_assert++;
    assert (data_word() !== PLAIN) else begin
      n_fail++;
      $error("FAIL rt_cipher_differs: observed %h expected not %h", data_word(), PLAIN);
    end
    run("rt_dec", 10'h164);
    chk("rt_data", data_word(), PLAIN);
    setup(32'd0, PLAIN);
    run("r0", 10'h080);
    chk("r0_data", data_word(), PLAIN);
    chk("r0_writes", 32'(wr_cnt), 32'd2);
    run("nop", 10'h000);
    chk("nop_valid_cycles", 32'(vld_cyc), 32'd0);
    delay_max = 5;
    setup(32'd1, PLAIN);
    run("slow", 10'h080);
    chk("slow_data", data_word(), CIPH1);
    chk("slow_addr_stable", 32'(unstable), 32'd0);
    delay_max = 0;
    setup(32'd1000, PLAIN);
    @(negedge clk);
    pc0 = 10'h080;
    xfers = 0;
    @(negedge clk);
    setb = 1'b1;
    for (int i = 0; i < 500 && xfers < 9; i++) @(negedge clk);
    chk("rr_loaded", 32'(xfers), 32'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    setb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_valid", 32'(valid), 32'd0);
    chk("rr_hold_idle", 32'(idle), 32'd1);
    chk("rr_data_untouched", data_word(), PLAIN);
    setup(32'd1, PLAIN);
    run("rr_rerun", 10'h080);
    chk("rr_rerun_data", data_word(), CIPH1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
